// File: rtl/eh2_mem_bank_arb_if.sv
// eh2_mem_bank_arb_if: requestor, response, SRAM bank and stall-counter
// signals shared between the arbiter and its neighbours.
interface eh2_mem_bank_arb_if #(
  parameter int NUM_CH    = 3,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 39,
  parameter int BANK_LSB  = 2,
  parameter int CNT_W     = 16
);
  localparam int BB    = $clog2(NUM_BANKS);
  localparam int IDX_W = ADDR_W - BANK_LSB - BB;

  logic [NUM_CH-1:0]                 req_valid;
  logic [NUM_CH-1:0]                 req_ready;
  logic [NUM_CH-1:0]                 req_we;
  logic [NUM_CH-1:0][ADDR_W-1:0]     req_addr;
  logic [NUM_CH-1:0][DATA_W-1:0]     req_wdata;
  logic [NUM_CH-1:0]                 rsp_valid;
  logic [NUM_CH-1:0][DATA_W-1:0]     rsp_rdata;
  logic [NUM_BANKS-1:0]              bank_en;
  logic [NUM_BANKS-1:0]              bank_we;
  logic [NUM_BANKS-1:0][IDX_W-1:0]   bank_addr;
  logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_wdata;
  logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_rdata;
  logic                              cnt_clr;
  logic [NUM_CH-1:0][CNT_W-1:0]      stall_cnt;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  bank_rdata, cnt_clr,
    output req_ready, rsp_valid, rsp_rdata,
    output bank_en, bank_we, bank_addr, bank_wdata,
    output stall_cnt
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output bank_rdata, cnt_clr,
    input  req_ready, rsp_valid, rsp_rdata,
    input  bank_en, bank_we, bank_addr, bank_wdata,
    input  stall_cnt
  );
endinterface

// File: rtl/eh2_mem_bank_arb.sv
// eh2_mem_bank_arb: per-bank round-robin arbiter over a banked SRAM with a
// fixed-latency read return path and saturating per-channel stall counters.
module eh2_mem_bank_arb #(
  parameter int NUM_CH    = 3,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 39,
  parameter int BANK_LSB  = 2,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  eh2_mem_bank_arb_if.slave bus
);
  localparam int BB    = $clog2(NUM_BANKS);
  localparam int IDX_W = ADDR_W - BANK_LSB - BB;
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

  logic [NUM_CH-1:0][BB-1:0]              ch_bank;
  logic [NUM_CH-1:0][IDX_W-1:0]           ch_idx;
  logic [NUM_BANKS-1:0][CW-1:0]           rr_q, rr_d;
  logic [NUM_BANKS-1:0]                   gnt;
  logic [NUM_BANKS-1:0][CW-1:0]           gnt_ch;
  logic [NUM_CH-1:0]                      ready;
  logic [NUM_BANKS-1:0][RD_LAT-1:0]       pv_q, pv_d;
  logic [NUM_BANKS-1:0][RD_LAT-1:0][CW-1:0] pc_q, pc_d;
  logic [NUM_CH-1:0][CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_CH-1:0]                      rsp_v;
  logic [NUM_CH-1:0][DATA_W-1:0]          rsp_d;
  logic [NUM_BANKS-1:0]                   b_we;
  logic [NUM_BANKS-1:0][IDX_W-1:0]        b_addr;
  logic [NUM_BANKS-1:0][DATA_W-1:0]       b_wdata;
  logic [CW-1:0]                          sel;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_bank[c] = bus.req_addr[c][BANK_LSB +: BB];
      ch_idx[c]  = bus.req_addr[c][ADDR_W-1 -: IDX_W];
    end
  end

  // first requesting channel at or after rr_q[b], wrapping modulo NUM_CH
  always_comb begin
    gnt    = '0;
    gnt_ch = '0;
    sel    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sel = CW'((int'(rr_q[b]) + k) % NUM_CH);
        if (!rst && !gnt[b] && bus.req_valid[sel] &&
            ch_bank[sel] == BB'(b)) begin
          gnt[b]    = 1'b1;
          gnt_ch[b] = sel;
        end
      end
    end
  end

  always_comb begin
    ready   = '0;
    b_we    = '0;
    b_addr  = '0;
    b_wdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rr_d[b] = rr_q[b];
      if (gnt[b]) begin
        ready[gnt_ch[b]] = 1'b1;
        b_we[b]    = bus.req_we[gnt_ch[b]];
        b_addr[b]  = ch_idx[gnt_ch[b]];
        b_wdata[b] = bus.req_wdata[gnt_ch[b]];
        rr_d[b]    = (gnt_ch[b] == LAST) ? '0 : gnt_ch[b] + 1'b1;
      end
    end
  end

  always_comb begin
    pv_d = pv_q;
    pc_d = pc_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      pv_d[b][0] = gnt[b] & ~bus.req_we[gnt_ch[b]];
      pc_d[b][0] = gnt_ch[b];
      for (int k = 1; k < RD_LAT; k++) begin
        pv_d[b][k] = pv_q[b][k-1];
        pc_d[b][k] = pc_q[b][k-1];
      end
    end
  end

  // a channel holds at most one grant per cycle, so returns never collide
  always_comb begin
    rsp_v = '0;
    rsp_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (pv_q[b][RD_LAT-1]) begin
        rsp_v[pc_q[b][RD_LAT-1]] = 1'b1;
        rsp_d[pc_q[b][RD_LAT-1]] = bus.bank_rdata[b];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (bus.cnt_clr) begin
        cnt_d[c] = '0;
      end else if (bus.req_valid[c] && !ready[c] && cnt_q[c] != '1) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      pv_q  <= '0;
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      pv_q  <= pv_d;
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.bank_en    = gnt;
  assign bus.bank_we    = b_we;
  assign bus.bank_addr  = b_addr;
  assign bus.bank_wdata = b_wdata;
  assign bus.rsp_valid  = rsp_v;
  assign bus.rsp_rdata  = rsp_d;
  assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_eh2_mem_bank_arb.sv
// tb_eh2_mem_bank_arb: directed scenarios plus random traffic checked
// against a cycle-level reference model of the arbiter.
module tb_eh2_mem_bank_arb;
  localparam int NUM_CH    = 3;
  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 39;
  localparam int BANK_LSB  = 2;
  localparam int RD_LAT    = 3;
  localparam int CNT_W     = 8;
  localparam int BB        = 2;
  localparam int IDX_W     = ADDR_W - BANK_LSB - BB;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  eh2_mem_bank_arb_if #(
    .NUM_CH(NUM_CH), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .BANK_LSB(BANK_LSB), .CNT_W(CNT_W)
  ) bus ();

  eh2_mem_bank_arb #(
    .NUM_CH(NUM_CH), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .BANK_LSB(BANK_LSB), .RD_LAT(RD_LAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int ch;
    int bank;
  } rsp_t;

  rsp_t pend[$];
  int   rr[NUM_BANKS];
  int   cnt[NUM_CH];
  int   win[NUM_BANKS];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  logic [NUM_CH-1:0]                exp_ready;
  logic [NUM_CH-1:0]                exp_rv;
  logic [NUM_CH-1:0][DATA_W-1:0]    exp_rd;
  logic [NUM_BANKS-1:0]             exp_en;
  logic [NUM_BANKS-1:0]             exp_we;
  logic [NUM_BANKS-1:0][IDX_W-1:0]  exp_addr;
  logic [NUM_BANKS-1:0][DATA_W-1:0] exp_wdata;

  function automatic int bank_of(logic [ADDR_W-1:0] a);
    return (int'(a) / (1 << BANK_LSB)) % NUM_BANKS;
  endfunction

  function automatic int idx_of(logic [ADDR_W-1:0] a);
    return int'(a) / ((1 << BANK_LSB) * NUM_BANKS);
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom(), $urandom()});
  endfunction

  // winner = requester with smallest cyclic distance from the bank pointer
  task automatic model_eval();
    int best;
    int d;
    exp_ready = '0; exp_en = '0; exp_we = '0;
    exp_addr = '0; exp_wdata = '0; exp_rv = '0; exp_rd = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      win[b] = -1;
      best = NUM_CH;
      for (int c = 0; c < NUM_CH; c++) begin
        d = (c - rr[b] + NUM_CH) % NUM_CH;
        if (!rst && bus.req_valid[c] &&
            bank_of(bus.req_addr[c]) == b && d < best) begin
          best = d;
          win[b] = c;
        end
      end
      if (win[b] >= 0) begin
        exp_ready[win[b]] = 1'b1;
        exp_en[b]    = 1'b1;
        exp_we[b]    = bus.req_we[win[b]];
        exp_addr[b]  = IDX_W'(idx_of(bus.req_addr[win[b]]));
        exp_wdata[b] = bus.req_wdata[win[b]];
      end
    end
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        exp_rv[pend[i].ch] = 1'b1;
        exp_rd[pend[i].ch] = bus.bank_rdata[pend[i].bank];
      end
    end
  endtask

  task automatic model_commit();
    rsp_t keep[$];
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) rr[b] = 0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
      pend.delete();
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (win[b] >= 0) begin
          rr[b] = (win[b] + 1) % NUM_CH;
          if (!bus.req_we[win[b]])
            pend.push_back('{cyc + RD_LAT, win[b], b});
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.cnt_clr) cnt[c] = 0;
        else if (bus.req_valid[c] && !exp_ready[c] && cnt[c] < CMAX)
          cnt[c] = cnt[c] + 1;
      end
      foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
      pend = keep;
    end
    cyc++;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
    for (int b = 0; b < NUM_BANKS; b++) bus.bank_rdata[b] = rnd_data();
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.cnt_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_we = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.req_addr[c]  = ADDR_W'(c * 4);
      bus.req_wdata[c] = rnd_data();
    end
    tick();
    tick();
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== '0) begin
      n_bad++;
      $display("FAIL reset_ready got %b exp 000", bus.req_ready);
    end
    n_cmp++;
    if (bus.bank_en !== '0 || bus.bank_we !== '0) begin
      n_bad++;
      $display("FAIL reset_bank_en_we got %b/%b exp 0/0",
               bus.bank_en, bus.bank_we);
    end
    n_cmp++;
    if (bus.bank_addr !== '0 || bus.bank_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_bank_bus got %h/%h exp 0",
               bus.bank_addr, bus.bank_wdata);
    end
    n_cmp++;
    if (bus.rsp_valid !== '0 || bus.rsp_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp got %b/%h exp 0",
               bus.rsp_valid, bus.rsp_rdata);
    end
    n_cmp++;
    if (bus.stall_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_stall got %h exp 0", bus.stall_cnt);
    end
    rst = 1'b0;
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b111 || exp_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL release_ready got %b exp 111", bus.req_ready);
    end
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      model_eval();
      #1;
      n_cmp++;
      if (bus.rsp_valid !== '0 || exp_rv !== '0) begin
        n_bad++;
        $display("FAIL midreset_rsp got %b exp 000", bus.rsp_valid);
      end
      tick();
    end
  endtask

  task automatic test_bank_conflict();
    int order[$];
    idle();
    bus.req_valid = 3'b111;
    for (int c = 0; c < NUM_CH; c++) bus.req_addr[c] = 16'h0010;
    for (int cy = 0; cy < 8; cy++) begin
      model_eval();
      #1;
      n_cmp++;
      if (bus.req_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL conflict_ready cy%0d got %b exp %b",
                 cy, bus.req_ready, exp_ready);
      end
      n_cmp++;
      if (bus.rsp_valid !== exp_rv || bus.rsp_rdata !== exp_rd) begin
        n_bad++;
        $display("FAIL conflict_rsp cy%0d got %b/%h exp %b/%h",
                 cy, bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
      end
      if (exp_ready != '0) begin
        n_cmp++;
        if (bus.bank_addr[0] !== IDX_W'(1) || bus.bank_en !== 4'b0001) begin
          n_bad++;
          $display("FAIL conflict_bank got %h/%b exp 1/0001",
                   bus.bank_addr[0], bus.bank_en);
        end
        for (int c = 0; c < NUM_CH; c++)
          if (exp_ready[c]) order.push_back(c);
      end
      tick();
      bus.req_valid = bus.req_valid & ~exp_ready;
    end
    n_cmp++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 ||
        order[2] != 2) begin
      n_bad++;
      $display("FAIL conflict_order got %p exp 0,1,2", order);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++;
      if (bus.stall_cnt[c] !== CNT_W'(c) || cnt[c] != c) begin
        n_bad++;
        $display("FAIL conflict_stall ch%0d got %0d exp %0d",
                 c, bus.stall_cnt[c], c);
      end
    end
  endtask

  task automatic test_parallel();
    idle();
    bus.req_valid = 3'b111;
    bus.req_we    = 3'b001;
    bus.req_addr[0] = 16'h0004;
    bus.req_addr[1] = 16'h0008;
    bus.req_addr[2] = 16'h000C;
    bus.req_wdata[0] = rnd_data();
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL par_ready got %b exp 111", bus.req_ready);
    end
    n_cmp++;
    if (bus.bank_en !== 4'b1110 || bus.bank_we !== 4'b0010) begin
      n_bad++;
      $display("FAIL par_bank got %b/%b exp 1110/0010",
               bus.bank_en, bus.bank_we);
    end
    n_cmp++;
    if (bus.bank_wdata[1] !== bus.req_wdata[0] ||
        bus.bank_addr[1] !== exp_addr[1]) begin
      n_bad++;
      $display("FAIL par_wbus got %h/%h exp %h/%h", bus.bank_wdata[1],
               bus.bank_addr[1], exp_wdata[1], exp_addr[1]);
    end
    tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      model_eval();
      #1;
      n_cmp++;
      if (bus.rsp_valid !== exp_rv || bus.rsp_rdata !== exp_rd) begin
        n_bad++;
        $display("FAIL par_rsp k%0d got %b/%h exp %b/%h", k,
                 bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
      end
      tick();
    end
  endtask

  task automatic test_rr_wrap();
    idle();
    bus.req_valid = 3'b100;
    bus.req_addr[2] = 16'h000C;
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b100 || exp_ready !== 3'b100) begin
      n_bad++;
      $display("FAIL rr_first got %b exp 100", bus.req_ready);
    end
    tick();
    bus.req_valid = 3'b101;
    bus.req_addr[0] = 16'h000C;
    bus.req_addr[2] = 16'h001C;
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b001 || exp_ready !== 3'b001) begin
      n_bad++;
      $display("FAIL rr_wrap got %b exp 001", bus.req_ready);
    end
    tick();
    bus.req_valid = 3'b011;
    bus.req_addr[1] = 16'h002C;
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b010 || exp_ready !== 3'b010) begin
      n_bad++;
      $display("FAIL rr_ptr1 got %b exp 010", bus.req_ready);
    end
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_latency();
    logic [DATA_W-1:0] pat;
    pat = 39'h5A5A5A5A5A;
    idle();
    bus.req_valid = 3'b010;
    bus.req_addr[1] = 16'h0008;
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b010) begin
      n_bad++;
      $display("FAIL lat_grant got %b exp 010", bus.req_ready);
    end
    tick();
    bus.req_valid = 3'b001;
    bus.req_we    = 3'b001;
    bus.req_addr[0] = 16'h0018;
    bus.req_wdata[0] = rnd_data();
    model_eval();
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b001 || bus.bank_we !== 4'b0100) begin
      n_bad++;
      $display("FAIL lat_write got %b/%b exp 001/0100",
               bus.req_ready, bus.bank_we);
    end
    tick();
    idle();
    for (int k = 2; k <= 5; k++) begin
      bus.bank_rdata[2] = pat;
      model_eval();
      #1;
      n_cmp++;
      if (bus.rsp_valid !== ((k == 3) ? 3'b010 : 3'b000) ||
          bus.rsp_valid !== exp_rv) begin
        n_bad++;
        $display("FAIL lat_valid k%0d got %b exp %b",
                 k, bus.rsp_valid, exp_rv);
      end
      if (k == 3) begin
        n_cmp++;
        if (bus.rsp_rdata[1] !== pat) begin
          n_bad++;
          $display("FAIL lat_data got %h exp %h", bus.rsp_rdata[1], pat);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    idle();
    for (int cy = 0; cy < 300; cy++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!bus.req_valid[c] && $urandom_range(0, 3) != 0) begin
          bus.req_valid[c] = 1'b1;
          bus.req_we[c]    = 1'($urandom_range(0, 1));
          bus.req_addr[c]  = ADDR_W'($urandom_range(0, 255));
          bus.req_wdata[c] = rnd_data();
        end
      end
      bus.cnt_clr = ($urandom_range(0, 49) == 0);
      model_eval();
      #1;
      n_cmp++;
      if (bus.req_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL rnd_ready cy%0d got %b exp %b",
                 cy, bus.req_ready, exp_ready);
      end
      n_cmp++;
      if (bus.bank_en !== exp_en || bus.bank_we !== exp_we) begin
        n_bad++;
        $display("FAIL rnd_bank cy%0d got %b/%b exp %b/%b",
                 cy, bus.bank_en, bus.bank_we, exp_en, exp_we);
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (exp_en[b]) begin
          n_cmp++;
          if (bus.bank_addr[b] !== exp_addr[b] ||
              bus.bank_wdata[b] !== exp_wdata[b]) begin
            n_bad++;
            $display("FAIL rnd_bus cy%0d b%0d got %h/%h exp %h/%h",
                     cy, b, bus.bank_addr[b], bus.bank_wdata[b],
                     exp_addr[b], exp_wdata[b]);
          end
        end
      end
      n_cmp++;
      if (bus.rsp_valid !== exp_rv || bus.rsp_rdata !== exp_rd) begin
        n_bad++;
        $display("FAIL rnd_rsp cy%0d got %b/%h exp %b/%h", cy,
                 bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        n_cmp++;
        if (bus.stall_cnt[c] !== CNT_W'(cnt[c])) begin
          n_bad++;
          $display("FAIL rnd_stall cy%0d ch%0d got %0d exp %0d",
                   cy, c, bus.stall_cnt[c], cnt[c]);
        end
      end
      tick();
      bus.req_valid = bus.req_valid & ~exp_ready;
    end
    idle();
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_counter();
    idle();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_we = '0;
    for (int c = 0; c < NUM_CH; c++) bus.req_addr[c] = 16'h0020;
    for (int k = 0; k < 450; k++) tick();
    model_eval();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++;
      if (bus.stall_cnt[c] !== CNT_W'(CMAX) || cnt[c] != CMAX) begin
        n_bad++;
        $display("FAIL cnt_sat ch%0d got %0d exp %0d",
                 c, bus.stall_cnt[c], CMAX);
      end
    end
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    model_eval();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++;
      if (bus.stall_cnt[c] !== '0 || cnt[c] != 0) begin
        n_bad++;
        $display("FAIL cnt_clr ch%0d got %0d exp 0", c, bus.stall_cnt[c]);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    pend.delete();
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.req_we     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.bank_rdata = '0;
    bus.cnt_clr    = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rr[b] = 0;
      win[b] = -1;
    end
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    @(negedge clk);
    test_reset();
    test_bank_conflict();
    test_parallel();
    test_rr_wrap();
    test_latency();
    test_random();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
